alu_clocks_control: RTL and testbench
=====================================

# alu_clocks_control

Processor core slice combining the phase clock generator, the microcode control decoder and the 8-bit ALU with its flag register. It sits between the instruction FSM/decoder and the bus-attached datapath (register file, PC, stack counter, MAR, IR, RAM). It turns the single system clock into three non-overlapping phase clocks, drives all bus control strobes from the current FSM state, and computes ALU results and carry/zero flags.

## Interface
- Parameters: none. All widths are fixed: 8-bit data, 4-bit ALU mode, 3-bit operands.
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `state` in 8: current FSM microstep code.
- `operand1` in 3: condition code field.
- `operand2` in 3: reserved; ignored.
- `alu_a`, `alu_b` in 8: ALU operands (register A and register B).
- `alu_mode` in 4: ALU operation select.
- `alu_out` out 8: ALU result; tri-state, high-Z unless `c_eo`=1.
- `flag_carry`, `flag_zero` out 1 each: registered flags.
- `cycle_clk`, `ram_clk`, `internal_clk` out 1 each: registered phase clocks.
- `halted` out 1: the core is stopped.
- `c_ii c_ci c_co c_cs c_rfi c_rfo c_eo c_ee` out 1 each: IR in, PC increment, PC out, PC set, regfile in, regfile out, ALU out, flag enable.
- `c_mi c_ro c_ri c_so c_sd c_si c_halt` out 1 each: MAR in, RAM out, RAM in, SP out, SP decrement, SP increment, halt.

## Operation
- **Clocks.** A 2-bit phase counter cycles 0→1→2→3→0.
  - Phase 0: `cycle_clk`=1.
  - Phase 1: `ram_clk`=1.
  - Phase 2: `internal_clk`=1.
  - Phase 3: all low.
  - Outputs are registered and never overlap.
- **Control.** Purely combinational from `state`. Every strobe not listed for a state is 0. Unlisted state codes drive all strobes to 0.
  - 0x00 FETCH_ADDR: co, mi.
  - 0x01 FETCH_INSTR: ro, ii, ci.
  - 0x02 MOV: rfo, rfi.
  - 0x03 ALU: eo, ee, rfi.
  - 0x04 IMM_ADDR: co, mi.
  - 0x05 IMM_DATA: ro, rfi, ci.
  - 0x06 LOAD_ADDR: rfo, mi.
  - 0x07 LOAD_DATA: ro, rfi.
  - 0x08 STORE_ADDR: rfo, mi.
  - 0x09 STORE_DATA: rfo, ri.
  - 0x0A JMP_ADDR: co, mi.
  - 0x0B JMP: if condition true then ro, cs; else ci.
  - 0x0C PUSH_ADDR: so, mi.
  - 0x0D PUSH_DATA: rfo, ri, sd.
  - 0x0E POP_INC: si.
  - 0x0F POP_ADDR: so, mi.
  - 0x10 POP_DATA: ro, rfi.
  - 0xFF HALT: halt.
- **Jump conditions** (`operand1`):
  - 0: always.
  - 1: zero=1.
  - 2: zero=0.
  - 3: carry=1.
  - 4: carry=0.
  - 5–7: never.
- **ALU.** Result is combinational.
  - 0 ADD: carry = bit 8 of the sum.
  - 1 SUB a−b: carry = borrow (a<b).
  - 2 AND, 3 OR, 4 XOR, 5 NOT a: carry = 0.
  - 6 SHL a: carry = a[7].
  - 7 SHR a: carry = a[0].
  - 8 INC a: carry = (a==0xFF).
  - 9 DEC a: carry = (a==0x00).
  - 10 PASS b: carry = 0.
  - 11–15: result 0x00, carry 0.
  - Results wrap modulo 256. Zero flag = (8-bit result == 0).

## Timing
- **Reset.** On a `clk` edge with `reset`=1:
  - Phase is set to 3.
  - All three phase clocks go to 0.
  - `halted`=0, `flag_carry`=0, `flag_zero`=0.
  - Reset wins over every other event, including mid-phase.
- The first edge after reset release enters phase 0 (`cycle_clk`=1). The period is 4 `clk` cycles.
- **Flags** are captured at the `clk` edge that raises `internal_clk` (entry to phase 2), and only if `c_ee`=1 at that edge. Otherwise they hold.
- **Halt.** If `c_halt`=1 at the edge leaving phase 2:
  - `halted` goes to 1 and the phase freezes at 3, with all clocks low.
  - The block stays halted until reset.
  - The halt microstep's `internal_clk` pulse still occurs.
- Control strobes and `alu_out` have zero latency from their inputs (combinational).

## Structure
- Shared package holds:
  - state code constants;
  - ALU mode constants;
  - condition code constants;
  - phase encoding.
- Three sub-blocks:
  - `phase_clock_gen`: phase counter, halt latch.
  - `control_decode`: combinational.
  - `alu_core`: combinational result/carry plus the flag register clocked by `clk`.

## Test plan
- Reset, then 8 clocks → `cycle_clk` high in cycles 1,5; `ram_clk` in 2,6; `internal_clk` in 3,7; never two high at once.
- mode 0, a=0xF0, b=0x20, eo=1, ee=1 → `alu_out`=0x10; after phase-2 entry carry=1, zero=0. mode 1, a=b=0x05 → 0x00, zero=1, carry=0. eo=0 → `alu_out` high-Z.
- state 0x01 → only ro, ii, ci high. state 0x42 → all strobes 0.
- state 0x0B, operand1=1, zero=1 → ro, cs high, ci low. zero=0 → only ci. operand1=0 → always jumps.
- state 0xFF through one full period → `halted`=1 after the internal pulse and clocks stay low for 20 cycles. Reset → restart at phase 0.
- Flags set, then reset asserted during phase 1 → flags 0, phase 3, clocks low on the next edge.

Source files
------------

// File: rtl/alu_clocks_control_pkg.sv
// rtl/alu_clocks_control_pkg.sv - shared constants for the clock/control/ALU slice
package alu_clocks_control_pkg;

    localparam logic [7:0] ST_FETCH_ADDR  = 8'h00;
    localparam logic [7:0] ST_FETCH_INSTR = 8'h01;
    localparam logic [7:0] ST_MOV         = 8'h02;
    localparam logic [7:0] ST_ALU         = 8'h03;
    localparam logic [7:0] ST_IMM_ADDR    = 8'h04;
    localparam logic [7:0] ST_IMM_DATA    = 8'h05;
    localparam logic [7:0] ST_LOAD_ADDR   = 8'h06;
    localparam logic [7:0] ST_LOAD_DATA   = 8'h07;
    localparam logic [7:0] ST_STORE_ADDR  = 8'h08;
    localparam logic [7:0] ST_STORE_DATA  = 8'h09;
    localparam logic [7:0] ST_JMP_ADDR    = 8'h0A;
    localparam logic [7:0] ST_JMP         = 8'h0B;
    localparam logic [7:0] ST_PUSH_ADDR   = 8'h0C;
    localparam logic [7:0] ST_PUSH_DATA   = 8'h0D;
    localparam logic [7:0] ST_POP_INC     = 8'h0E;
    localparam logic [7:0] ST_POP_ADDR    = 8'h0F;
    localparam logic [7:0] ST_POP_DATA    = 8'h10;
    localparam logic [7:0] ST_HALT        = 8'hFF;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_INC  = 4'd8;
    localparam logic [3:0] ALU_DEC  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_C      = 3'd3;
    localparam logic [2:0] COND_NC     = 3'd4;

    typedef enum logic [1:0] {
        PH_CYCLE    = 2'd0,
        PH_RAM      = 2'd1,
        PH_INTERNAL = 2'd2,
        PH_IDLE     = 2'd3
    } phase_e;

    typedef struct packed {
        logic ii, ci, co, cs, rfi, rfo, eo, ee;
        logic mi, ro, ri, so, sd, si, halt;
    } ctrl_t;

endpackage

// File: rtl/alu_clocks_control_alu_core.sv
// rtl/alu_clocks_control_alu_core.sv - 8-bit combinational ALU with carry/zero flag register
module alu_clocks_control_alu_core
    import alu_clocks_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [3:0] mode_i,
    input  logic       capture_i,
    output logic [7:0] result_o,
    output logic       flag_carry_o,
    output logic       flag_zero_o
);

    logic carry;
    logic carry_q, carry_d;
    logic zero_q, zero_d;

    always_comb begin
        result_o = 8'h00;
        carry    = 1'b0;
        case (mode_i)
            ALU_ADD:  {carry, result_o} = {1'b0, a_i} + {1'b0, b_i};
            ALU_SUB:  begin result_o = a_i - b_i; carry = (a_i < b_i); end
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOT:  result_o = ~a_i;
            ALU_SHL:  begin result_o = {a_i[6:0], 1'b0}; carry = a_i[7]; end
            ALU_SHR:  begin result_o = {1'b0, a_i[7:1]}; carry = a_i[0]; end
            ALU_INC:  begin result_o = a_i + 8'd1; carry = (a_i == 8'hFF); end
            ALU_DEC:  begin result_o = a_i - 8'd1; carry = (a_i == 8'h00); end
            ALU_PASS: result_o = b_i;
            default:  ;
        endcase
    end

    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (capture_i) begin
            carry_d = carry;
            zero_d  = (result_o == 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign flag_carry_o = carry_q;
    assign flag_zero_o  = zero_q;

endmodule

// File: rtl/alu_clocks_control_control_decode.sv
// rtl/alu_clocks_control_control_decode.sv - microstep code to bus strobe decoder
module alu_clocks_control_control_decode
    import alu_clocks_control_pkg::*;
(
    input  logic [7:0] state_i,
    input  logic [2:0] cond_i,
    input  logic       flag_carry_i,
    input  logic       flag_zero_i,
    output ctrl_t      ctrl_o
);

    logic take_jump;

    always_comb begin
        case (cond_i)
            COND_ALWAYS: take_jump = 1'b1;
            COND_Z:      take_jump = flag_zero_i;
            COND_NZ:     take_jump = !flag_zero_i;
            COND_C:      take_jump = flag_carry_i;
            COND_NC:     take_jump = !flag_carry_i;
            default:     take_jump = 1'b0;
        endcase
    end

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH_ADDR, ST_IMM_ADDR, ST_JMP_ADDR: begin ctrl_o.co = 1'b1; ctrl_o.mi = 1'b1; end
            ST_FETCH_INSTR: begin ctrl_o.ro = 1'b1; ctrl_o.ii = 1'b1; ctrl_o.ci = 1'b1; end
            ST_MOV:         begin ctrl_o.rfo = 1'b1; ctrl_o.rfi = 1'b1; end
            ST_ALU:         begin ctrl_o.eo = 1'b1; ctrl_o.ee = 1'b1; ctrl_o.rfi = 1'b1; end
            ST_IMM_DATA:    begin ctrl_o.ro = 1'b1; ctrl_o.rfi = 1'b1; ctrl_o.ci = 1'b1; end
            ST_LOAD_ADDR, ST_STORE_ADDR: begin ctrl_o.rfo = 1'b1; ctrl_o.mi = 1'b1; end
            ST_LOAD_DATA, ST_POP_DATA:   begin ctrl_o.ro = 1'b1; ctrl_o.rfi = 1'b1; end
            ST_STORE_DATA:  begin ctrl_o.rfo = 1'b1; ctrl_o.ri = 1'b1; end
            ST_JMP: begin
                if (take_jump) begin
                    ctrl_o.ro = 1'b1;
                    ctrl_o.cs = 1'b1;
                end else begin
                    ctrl_o.ci = 1'b1;
                end
            end
            ST_PUSH_ADDR, ST_POP_ADDR: begin ctrl_o.so = 1'b1; ctrl_o.mi = 1'b1; end
            ST_PUSH_DATA:   begin ctrl_o.rfo = 1'b1; ctrl_o.ri = 1'b1; ctrl_o.sd = 1'b1; end
            ST_POP_INC:     ctrl_o.si = 1'b1;
            ST_HALT:        ctrl_o.halt = 1'b1;
            default:        ;
        endcase
    end

endmodule

// File: rtl/alu_clocks_control_phase_clock_gen.sv
// rtl/alu_clocks_control_phase_clock_gen.sv - four-phase counter, phase clocks and halt latch
module alu_clocks_control_phase_clock_gen
    import alu_clocks_control_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic halt_req_i,
    output logic cycle_clk_o,
    output logic ram_clk_o,
    output logic internal_clk_o,
    output logic halted_o,
    output logic flag_capture_o
);

    phase_e     phase_q, phase_d;
    logic       halted_q, halted_d;
    logic [2:0] clocks_q, clocks_d;

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        clocks_d = 3'b000;
        if (halted_q) begin
            phase_d = PH_IDLE;
        end else if (phase_q == PH_INTERNAL && halt_req_i) begin
            halted_d = 1'b1;
            phase_d  = PH_IDLE;
        end else begin
            phase_d = phase_e'(phase_q + 2'd1);
        end
        // Clocks are decoded from the next phase so they switch on the same edge
        case (phase_d)
            PH_CYCLE:    clocks_d = 3'b100;
            PH_RAM:      clocks_d = 3'b010;
            PH_INTERNAL: clocks_d = 3'b001;
            default:     clocks_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q  <= PH_IDLE;
            halted_q <= 1'b0;
            clocks_q <= 3'b000;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            clocks_q <= clocks_d;
        end
    end

    assign {cycle_clk_o, ram_clk_o, internal_clk_o} = clocks_q;
    assign halted_o       = halted_q;
    assign flag_capture_o = (phase_q == PH_RAM) && !halted_q;

endmodule

// File: rtl/alu_clocks_control.sv
// rtl/alu_clocks_control.sv - core slice: phase clocks, microcode control strobes and ALU
module alu_clocks_control
    import alu_clocks_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] state,
    input  logic [2:0] operand1,
    input  logic [2:0] operand2,
    input  logic [7:0] alu_a,
    input  logic [7:0] alu_b,
    input  logic [3:0] alu_mode,
    output wire  [7:0] alu_out,
    output logic       flag_carry,
    output logic       flag_zero,
    output logic       cycle_clk,
    output logic       ram_clk,
    output logic       internal_clk,
    output logic       halted,
    output logic       c_ii,
    output logic       c_ci,
    output logic       c_co,
    output logic       c_cs,
    output logic       c_rfi,
    output logic       c_rfo,
    output logic       c_eo,
    output logic       c_ee,
    output logic       c_mi,
    output logic       c_ro,
    output logic       c_ri,
    output logic       c_so,
    output logic       c_sd,
    output logic       c_si,
    output logic       c_halt
);

    ctrl_t      ctrl;
    logic       flag_capture;
    logic [7:0] alu_result;
    logic       unused_operand2;

    assign unused_operand2 = ^operand2;

    alu_clocks_control_phase_clock_gen u_phase (
        .clk            (clk),
        .reset          (reset),
        .halt_req_i     (ctrl.halt),
        .cycle_clk_o    (cycle_clk),
        .ram_clk_o      (ram_clk),
        .internal_clk_o (internal_clk),
        .halted_o       (halted),
        .flag_capture_o (flag_capture)
    );

    alu_clocks_control_control_decode u_decode (
        .state_i      (state),
        .cond_i       (operand1),
        .flag_carry_i (flag_carry),
        .flag_zero_i  (flag_zero),
        .ctrl_o       (ctrl)
    );

    alu_clocks_control_alu_core u_alu (
        .clk          (clk),
        .reset        (reset),
        .a_i          (alu_a),
        .b_i          (alu_b),
        .mode_i       (alu_mode),
        .capture_i    (flag_capture && ctrl.ee),
        .result_o     (alu_result),
        .flag_carry_o (flag_carry),
        .flag_zero_o  (flag_zero)
    );

    assign alu_out = ctrl.eo ? alu_result : 8'bzzzz_zzzz;

    assign {c_ii, c_ci, c_co, c_cs, c_rfi, c_rfo, c_eo, c_ee} =
           {ctrl.ii, ctrl.ci, ctrl.co, ctrl.cs, ctrl.rfi, ctrl.rfo, ctrl.eo, ctrl.ee};
    assign {c_mi, c_ro, c_ri, c_so, c_sd, c_si, c_halt} =
           {ctrl.mi, ctrl.ro, ctrl.ri, ctrl.so, ctrl.sd, ctrl.si, ctrl.halt};

endmodule

// File: tb/tb_alu_clocks_control.sv
// tb/tb_alu_clocks_control.sv - self-checking bench for alu_clocks_control
module tb_alu_clocks_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] state;
    logic [2:0] operand1, operand2;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_mode;
    wire  [7:0] alu_out;
    logic flag_carry, flag_zero, cycle_clk, ram_clk, internal_clk, halted;
    logic c_ii, c_ci, c_co, c_cs, c_rfi, c_rfo, c_eo, c_ee;
    logic c_mi, c_ro, c_ri, c_so, c_sd, c_si, c_halt;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q[$];
    logic [15:0] exp_v;

    always #5 clk = ~clk;

    alu_clocks_control dut (
        .clk(clk), .reset(reset), .state(state), .operand1(operand1), .operand2(operand2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_out(alu_out),
        .flag_carry(flag_carry), .flag_zero(flag_zero), .cycle_clk(cycle_clk),
        .ram_clk(ram_clk), .internal_clk(internal_clk), .halted(halted),
        .c_ii(c_ii), .c_ci(c_ci), .c_co(c_co), .c_cs(c_cs), .c_rfi(c_rfi), .c_rfo(c_rfo),
        .c_eo(c_eo), .c_ee(c_ee), .c_mi(c_mi), .c_ro(c_ro), .c_ri(c_ri), .c_so(c_so),
        .c_sd(c_sd), .c_si(c_si), .c_halt(c_halt)
    );

    wire [14:0] strobes = {c_ii, c_ci, c_co, c_cs, c_rfi, c_rfo, c_eo, c_ee,
                           c_mi, c_ro, c_ri, c_so, c_sd, c_si, c_halt};
    wire [2:0]  clks    = {cycle_clk, ram_clk, internal_clk};

    // {state, expected strobes ii ci co cs rfi rfo eo ee mi ro ri so sd si halt}
    localparam logic [22:0] CTRL_VEC [20] = '{
        {8'h00, 15'h1040}, {8'h01, 15'h6020}, {8'h02, 15'h0600}, {8'h03, 15'h0580},
        {8'h04, 15'h1040}, {8'h05, 15'h2420}, {8'h06, 15'h0240}, {8'h07, 15'h0420},
        {8'h08, 15'h0240}, {8'h09, 15'h0210}, {8'h0A, 15'h1040}, {8'h0C, 15'h0048},
        {8'h0D, 15'h0214}, {8'h0E, 15'h0002}, {8'h0F, 15'h0048}, {8'h10, 15'h0420},
        {8'hFF, 15'h0001}, {8'h42, 15'h0000}, {8'h11, 15'h0000}, {8'hFE, 15'h0000}
    };

    // {mode, a, b, result, carry, zero}
    localparam logic [29:0] ALU_VEC [13] = '{
        {4'd0,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0},
        {4'd1,  8'h05, 8'h05, 8'h00, 1'b0, 1'b1},
        {4'd1,  8'h03, 8'h05, 8'hFE, 1'b1, 1'b0},
        {4'd2,  8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0},
        {4'd3,  8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0},
        {4'd4,  8'hCC, 8'hCC, 8'h00, 1'b0, 1'b1},
        {4'd5,  8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0},
        {4'd6,  8'h81, 8'h00, 8'h02, 1'b1, 1'b0},
        {4'd7,  8'h01, 8'h00, 8'h00, 1'b1, 1'b1},
        {4'd8,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b1},
        {4'd9,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0},
        {4'd10, 8'h77, 8'h5A, 8'h5A, 1'b0, 1'b0},
        {4'd12, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase2();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = internal_clk;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_phase2: internal_clk=%b required 1 within 8 cycles", internal_clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        state = 8'h42;
        tick();
        tick();
        checks++;
        if (clks !== 3'b000) begin errors++; $display("FAIL reset_clocks: got %b required 000", clks); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b required 0", halted); end
        checks++;
        if ({flag_carry, flag_zero} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b%b required 00", flag_carry, flag_zero);
        end
    endtask

    task automatic test_control();
        for (int i = 0; i < 20; i++) begin
            state = CTRL_VEC[i][22:15];
            #1;
            checks++;
            if (strobes !== CTRL_VEC[i][14:0]) begin
                errors++;
                $display("FAIL control state=%h: got %h required %h", state, strobes, CTRL_VEC[i][14:0]);
            end
        end
        state = 8'h42;
    endtask

    task automatic test_clocks();
        reset = 1'b0;
        for (int c = 1; c <= 8; c++)
            sb_q.push_back((c % 4 == 1) ? 16'd4 : (c % 4 == 2) ? 16'd2 : (c % 4 == 3) ? 16'd1 : 16'd0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if (clks !== exp_v[2:0]) begin
                errors++; $display("FAIL clocks cycle %0d: got %b required %b", c, clks, exp_v[2:0]);
            end
        end
    endtask

    task automatic test_alu();
        state = 8'h03;
        for (int i = 0; i < 13; i++) begin
            alu_mode = ALU_VEC[i][29:26];
            alu_a    = ALU_VEC[i][25:18];
            alu_b    = ALU_VEC[i][17:10];
            sb_q.push_back({14'd0, ALU_VEC[i][1:0]});
            #1;
            checks++;
            if (alu_out !== ALU_VEC[i][9:2]) begin
                errors++; $display("FAIL alu_out mode=%0d: got %h required %h", alu_mode, alu_out, ALU_VEC[i][9:2]);
            end
            wait_phase2();
            exp_v = sb_q.pop_front();
            checks++;
            if ({flag_carry, flag_zero} !== exp_v[1:0]) begin
                errors++;
                $display("FAIL alu_flags mode=%0d: got c=%b z=%b required %b", alu_mode, flag_carry, flag_zero, exp_v[1:0]);
            end
        end
        // Without ee the flags must hold the last captured values (c=0 z=1)
        state    = 8'h42;
        alu_mode = 4'd0;
        alu_a    = 8'hFF;
        alu_b    = 8'hFF;
        sb_q.push_back(16'b01);
        wait_phase2();
        exp_v = sb_q.pop_front();
        checks++;
        if ({flag_carry, flag_zero} !== exp_v[1:0]) begin
            errors++; $display("FAIL flag_hold: got %b%b required %b", flag_carry, flag_zero, exp_v[1:0]);
        end
        alu_a = 8'h12;
        alu_b = 8'h34;
        #1;
        checks++;
        // An undriven bus may also read as 0 in a two-state simulator
        if (alu_out !== 8'hzz && alu_out !== 8'h00) begin
            errors++; $display("FAIL alu_out_hiz: got %h required zz", alu_out);
        end
    endtask

    task automatic test_jmp();
        logic [7:0] exp_take;
        for (int pass = 0; pass < 2; pass++) begin
            state    = 8'h03;
            alu_mode = (pass == 0) ? 4'd1 : 4'd0;
            alu_a    = (pass == 0) ? 8'h05 : 8'hF0;
            alu_b    = (pass == 0) ? 8'h05 : 8'h20;
            wait_phase2();
            // bit n = jump taken for operand1 n; pass 0 has z=1 c=0, pass 1 has z=0 c=1
            exp_take = (pass == 0) ? 8'b0001_0011 : 8'b0000_1101;
            state = 8'h0B;
            for (int op = 0; op < 8; op++) begin
                operand1 = op[2:0];
                #1;
                checks++;
                if ({c_ro, c_cs, c_ci} !== (exp_take[op] ? 3'b110 : 3'b001)) begin
                    errors++;
                    $display("FAIL jmp z=%b c=%b cond=%0d: got ro,cs,ci=%b required %b", flag_zero,
                             flag_carry, op, {c_ro, c_cs, c_ci}, exp_take[op] ? 3'b110 : 3'b001);
                end
            end
        end
        state    = 8'h42;
        operand1 = 3'd0;
    endtask

    task automatic test_halt();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        state = 8'hFF;
        sb_q.push_back(16'b0_100);
        sb_q.push_back(16'b0_010);
        sb_q.push_back(16'b0_001);
        sb_q.push_back(16'b1_000);
        for (int c = 0; c < 4; c++) begin
            tick();
            exp_v = sb_q.pop_front();
            checks++;
            if ({halted, clks} !== exp_v[3:0]) begin
                errors++; $display("FAIL halt_entry step %0d: got %b required %b", c, {halted, clks}, exp_v[3:0]);
            end
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({halted, clks} !== 4'b1000) begin
                errors++; $display("FAIL halt_hold cycle %0d: got %b required 1000", c, {halted, clks});
            end
        end
        state = 8'h42;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({halted, clks} !== 4'b0100) begin
            errors++; $display("FAIL halt_restart: got %b required 0100", {halted, clks});
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        state    = 8'h03;
        alu_mode = 4'd0;
        alu_a    = 8'hF0;
        alu_b    = 8'h20;
        wait_phase2();
        checks++;
        if ({flag_carry, flag_zero} !== 2'b10) begin
            errors++; $display("FAIL mid_setup_flags: got %b%b required 10", flag_carry, flag_zero);
        end
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = ram_clk;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_wait_phase1: ram_clk=%b required 1", ram_clk); end
        reset = 1'b1;
        tick();
        checks++;
        if ({halted, clks, flag_carry, flag_zero} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: got halted,clks,c,z=%b required 000000", {halted, clks, flag_carry, flag_zero});
        end
        reset = 1'b0;
        state = 8'h42;
        tick();
        checks++;
        if (clks !== 3'b100) begin errors++; $display("FAIL mid_restart: got %b required 100", clks); end
    endtask

    initial begin
        reset    = 1'b1;
        state    = 8'h42;
        operand1 = 3'd0;
        operand2 = 3'd5;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_mode = 4'd0;
        test_reset();
        test_control();
        test_clocks();
        test_alu();
        test_jmp();
        test_halt();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
